// File: rtl/board_defs.sv
// Board geometry, cell codes and direction vectors shared by the game-logic stages and the painter.
package board_defs;

    localparam int BOARD_WIDTH  = 16;
    localparam int BOARD_HEIGHT = 16;
    localparam int WIN_LENGTH   = 5;
    localparam int CELLS        = BOARD_WIDTH * BOARD_HEIGHT;
    localparam int BOARD_BITS   = CELLS * 2;
    localparam int IDX_W        = $clog2(BOARD_BITS);

    localparam logic [1:0] CHESS_WITH_NONE  = 2'd0;
    localparam logic [1:0] CHESS_WITH_BLACK = 2'd1;
    localparam logic [1:0] CHESS_WITH_BLUE  = 2'd2;
    localparam logic [1:0] CHESS_WITH_WIN   = 2'd3;

    localparam logic [1:0] WINNING_GAMING = 2'b00;
    localparam logic [1:0] WINNING_EQUAL  = 2'b01;
    localparam logic [1:0] WINNING_BLACK  = 2'b10;
    localparam logic [1:0] WINNING_BLUE   = 2'b11;

    typedef logic signed [4:0] coord_t;
    typedef logic [IDX_W-1:0]  bit_idx_t;

    localparam coord_t X_MAX = coord_t'(BOARD_WIDTH - 1);
    localparam coord_t Y_MAX = coord_t'(BOARD_HEIGHT - 1);

    // dir 0..3: horizontal, vertical, diagonal, anti-diagonal
    localparam coord_t DIR_DX [4] = '{5'sd1, 5'sd0, 5'sd1, 5'sd1};
    localparam coord_t DIR_DY [4] = '{5'sd0, 5'sd1, 5'sd1, -5'sd1};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WALK_POS,
        ST_WALK_NEG,
        ST_EVAL,
        ST_MARK,
        ST_DONE
    } state_t;

    function automatic int cell_index(coord_t x, coord_t y);
        return int'(y) * BOARD_WIDTH + int'(x);
    endfunction

    // Low bit of the 2-bit slice holding cell (x,y); only meaningful for in-bounds coordinates.
    function automatic bit_idx_t cell_lo(coord_t x, coord_t y);
        return bit_idx_t'(cell_index(x, y) * 2);
    endfunction

endpackage

// File: rtl/win_checker_if.sv
// Continuation handshake plus board in/out between the move stage, the win checker and the painter.
interface win_checker_if;
    import board_defs::*;

    logic                  in_cont_signal;
    logic                  out_cont_signal;
    logic                  next_out_cont_signal;
    logic [BOARD_BITS-1:0] board;
    logic [3:0]            last_x;
    logic [3:0]            last_y;
    logic [BOARD_BITS-1:0] board_marked;
    logic [1:0]            winning_information;

    modport master (
        output in_cont_signal, next_out_cont_signal, board, last_x, last_y,
        input  out_cont_signal, board_marked, winning_information
    );

    modport slave (
        input  in_cont_signal, next_out_cont_signal, board, last_x, last_y,
        output out_cont_signal, board_marked, winning_information
    );

endinterface

// File: rtl/win_checker_line_walker.sv
// One step of a line walk: next cursor along (optionally negated) dir, bounds check and colour match.
module line_walker
    import board_defs::*;
(
    input  logic [BOARD_BITS-1:0] board,
    input  coord_t                cur_x,
    input  coord_t                cur_y,
    input  logic [1:0]            dir,
    input  logic                  neg,
    input  logic [1:0]            colour,
    output coord_t                nxt_x,
    output coord_t                nxt_y,
    output logic                  match
);

    coord_t   dx;
    coord_t   dy;
    logic     in_bounds;
    bit_idx_t lo;

    always_comb begin
        dx        = neg ? -DIR_DX[dir] : DIR_DX[dir];
        dy        = neg ? -DIR_DY[dir] : DIR_DY[dir];
        nxt_x     = cur_x + dx;
        nxt_y     = cur_y + dy;
        // Signed coordinates make off-edge steps negative or past max, so nothing wraps.
        in_bounds = (nxt_x >= 5'sd0) && (nxt_x <= X_MAX) &&
                    (nxt_y >= 5'sd0) && (nxt_y <= Y_MAX);
        lo        = in_bounds ? cell_lo(nxt_x, nxt_y) : '0;
        match     = in_bounds && (board[lo +: 2] == colour);
    end

endmodule

// File: rtl/win_checker.sv
// Checks the four lines through the last move for a winning run and marks the run for the painter.
//   state    | meaning
//   IDLE     | waiting for in_cont_signal
//   WALK_POS | stepping along +dir counting same-colour stones
//   WALK_NEG | stepping along -dir counting same-colour stones
//   EVAL     | judge run length, next direction or start marking
//   MARK     | recolour winning run cells to 3, one per cycle
//   DONE     | outputs valid, waiting for next_out_cont_signal
module win_checker
    import board_defs::*;
(
    input  logic          Clck,
    input  logic          Reset,
    win_checker_if.slave  bus
);

    localparam logic [2:0] WALK_CAP   = 3'(WIN_LENGTH - 1);
    localparam logic [3:0] WIN_RUN    = 4'(WIN_LENGTH);
    localparam logic [8:0] CELL_COUNT = 9'(CELLS);

    state_t                state_q, state_nxt;
    logic [1:0]            dir_q, dir_nxt;
    coord_t                org_x_q, org_x_nxt, org_y_q, org_y_nxt;
    coord_t                cur_x_q, cur_x_nxt, cur_y_q, cur_y_nxt;
    logic [1:0]            colour_q, colour_nxt;
    logic [2:0]            pos_len_q, pos_len_nxt, neg_len_q, neg_len_nxt;
    logic [3:0]            mark_left_q, mark_left_nxt;
    logic [8:0]            move_count_q, move_count_nxt;
    logic                  out_cont_q, out_cont_nxt;
    logic [1:0]            info_q, info_nxt;
    logic [BOARD_BITS-1:0] marked_q, marked_nxt;

    coord_t     step_x, step_y;
    logic       step_match;
    logic [3:0] run;
    coord_t     back_len;
    coord_t     last_xs, last_ys;
    logic [1:0] org_colour;

    line_walker u_walker (
        .board  (bus.board),
        .cur_x  (cur_x_q),
        .cur_y  (cur_y_q),
        .dir    (dir_q),
        .neg    (state_q == ST_WALK_NEG),
        .colour (colour_q),
        .nxt_x  (step_x),
        .nxt_y  (step_y),
        .match  (step_match)
    );

    always_ff @(posedge Clck or negedge Reset) begin
        if (!Reset) begin
            state_q      <= ST_IDLE;
            dir_q        <= '0;
            org_x_q      <= '0;
            org_y_q      <= '0;
            cur_x_q      <= '0;
            cur_y_q      <= '0;
            colour_q     <= '0;
            pos_len_q    <= '0;
            neg_len_q    <= '0;
            mark_left_q  <= '0;
            move_count_q <= '0;
            out_cont_q   <= 1'b0;
            info_q       <= WINNING_GAMING;
            marked_q     <= '0;
        end else begin
            state_q      <= state_nxt;
            dir_q        <= dir_nxt;
            org_x_q      <= org_x_nxt;
            org_y_q      <= org_y_nxt;
            cur_x_q      <= cur_x_nxt;
            cur_y_q      <= cur_y_nxt;
            colour_q     <= colour_nxt;
            pos_len_q    <= pos_len_nxt;
            neg_len_q    <= neg_len_nxt;
            mark_left_q  <= mark_left_nxt;
            move_count_q <= move_count_nxt;
            out_cont_q   <= out_cont_nxt;
            info_q       <= info_nxt;
            marked_q     <= marked_nxt;
        end
    end

    always_comb begin
        state_nxt      = state_q;
        dir_nxt        = dir_q;
        org_x_nxt      = org_x_q;
        org_y_nxt      = org_y_q;
        cur_x_nxt      = cur_x_q;
        cur_y_nxt      = cur_y_q;
        colour_nxt     = colour_q;
        pos_len_nxt    = pos_len_q;
        neg_len_nxt    = neg_len_q;
        mark_left_nxt  = mark_left_q;
        move_count_nxt = move_count_q;
        out_cont_nxt   = out_cont_q;
        info_nxt       = info_q;
        marked_nxt     = marked_q;

        last_xs    = coord_t'({1'b0, bus.last_x});
        last_ys    = coord_t'({1'b0, bus.last_y});
        org_colour = bus.board[cell_lo(last_xs, last_ys) +: 2];
        run        = 4'd1 + {1'b0, pos_len_q} + {1'b0, neg_len_q};
        back_len   = coord_t'({2'b00, neg_len_q});

        case (state_q)
            ST_IDLE: begin
                if (bus.in_cont_signal && !out_cont_q) begin
                    org_x_nxt   = last_xs;
                    org_y_nxt   = last_ys;
                    cur_x_nxt   = last_xs;
                    cur_y_nxt   = last_ys;
                    colour_nxt  = org_colour;
                    marked_nxt  = bus.board;
                    dir_nxt     = 2'd0;
                    pos_len_nxt = '0;
                    neg_len_nxt = '0;
                    // Empty/marked origin or an already decided game: hand the board straight on.
                    if (org_colour == CHESS_WITH_NONE || org_colour == CHESS_WITH_WIN ||
                        info_q != WINNING_GAMING) begin
                        out_cont_nxt = 1'b1;
                        state_nxt    = ST_DONE;
                    end else begin
                        state_nxt = ST_WALK_POS;
                    end
                end
            end
            ST_WALK_POS: begin
                if (step_match) pos_len_nxt = pos_len_q + 3'd1;
                if (!step_match || pos_len_q == WALK_CAP - 3'd1) begin
                    cur_x_nxt = org_x_q;
                    cur_y_nxt = org_y_q;
                    state_nxt = ST_WALK_NEG;
                end else begin
                    cur_x_nxt = step_x;
                    cur_y_nxt = step_y;
                end
            end
            ST_WALK_NEG: begin
                if (step_match) neg_len_nxt = neg_len_q + 3'd1;
                if (!step_match || neg_len_q == WALK_CAP - 3'd1) begin
                    cur_x_nxt = org_x_q;
                    cur_y_nxt = org_y_q;
                    state_nxt = ST_EVAL;
                end else begin
                    cur_x_nxt = step_x;
                    cur_y_nxt = step_y;
                end
            end
            ST_EVAL: begin
                if (run >= WIN_RUN) begin
                    info_nxt      = (colour_q == CHESS_WITH_BLACK) ? WINNING_BLACK : WINNING_BLUE;
                    cur_x_nxt     = org_x_q - back_len * DIR_DX[dir_q];
                    cur_y_nxt     = org_y_q - back_len * DIR_DY[dir_q];
                    mark_left_nxt = run;
                    state_nxt     = ST_MARK;
                end else begin
                    pos_len_nxt = '0;
                    neg_len_nxt = '0;
                    cur_x_nxt   = org_x_q;
                    cur_y_nxt   = org_y_q;
                    if (dir_q == 2'd3) begin
                        move_count_nxt = move_count_q + 9'd1;
                        if (move_count_nxt == CELL_COUNT) info_nxt = WINNING_EQUAL;
                        out_cont_nxt = 1'b1;
                        state_nxt    = ST_DONE;
                    end else begin
                        dir_nxt   = dir_q + 2'd1;
                        state_nxt = ST_WALK_POS;
                    end
                end
            end
            ST_MARK: begin
                marked_nxt[cell_lo(cur_x_q, cur_y_q) +: 2] = CHESS_WITH_WIN;
                cur_x_nxt     = step_x;
                cur_y_nxt     = step_y;
                mark_left_nxt = mark_left_q - 4'd1;
                if (mark_left_q == 4'd1) begin
                    move_count_nxt = move_count_q + 9'd1;
                    out_cont_nxt   = 1'b1;
                    state_nxt      = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.next_out_cont_signal) begin
                    out_cont_nxt = 1'b0;
                    state_nxt    = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign bus.out_cont_signal     = out_cont_q;
    assign bus.winning_information = info_q;
    assign bus.board_marked        = marked_q;

endmodule

// File: tb/tb_win_checker.sv
// Directed bench for win_checker: latencies, win marking, edge/no-wrap cases, draw, skip and reset abort.
module tb_win_checker;
    import board_defs::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    win_checker_if bus();

    win_checker dut (
        .Clck  (clk),
        .Reset (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] put(input logic [511:0] b, input int x, input int y,
                                         input logic [1:0] v);
        logic [511:0] r;
        r = b;
        r[(y * 16 + x) * 2 +: 2] = v;
        return r;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        bus.in_cont_signal = 1'b0;
        bus.next_out_cont_signal = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Start a check; lat = edges from the accepting edge to out_cont_signal high, -1 on timeout.
    task automatic run_check(output int lat);
        bit seen;
        @(negedge clk);
        bus.in_cont_signal = 1'b1;
        @(posedge clk);
        #1;
        bus.in_cont_signal = 1'b0;
        lat = -1;
        seen = bus.out_cont_signal;
        if (seen) lat = 0;
        for (int k = 1; k <= 200 && !seen; k++) begin
            @(posedge clk);
            #1;
            if (bus.out_cont_signal) begin
                seen = 1'b1;
                lat = k;
            end
        end
    endtask

    task automatic release_out();
        @(negedge clk);
        bus.next_out_cont_signal = 1'b1;
        @(posedge clk);
        #1;
        bus.next_out_cont_signal = 1'b0;
    endtask

    logic [511:0] b;
    logic [511:0] exp_b;
    int           lat;
    int           bad_lat;
    int           hi;

    initial begin
        checks = 0;
        failures = 0;
        b = '0;
        bus.board = '0;
        bus.last_x = 4'd0;
        bus.last_y = 4'd0;
        do_reset();
        #1;
        check_eq("rst_out_cont", 512'(bus.out_cont_signal), 512'(0));
        check_eq("rst_info", 512'(bus.winning_information), 512'(0));
        check_eq("rst_marked", bus.board_marked, '0);

        // Lone stone
        b = put('0, 7, 7, 2'd1);
        bus.board = b; bus.last_x = 4'd7; bus.last_y = 4'd7;
        run_check(lat);
        check_eq("lone_lat", 512'(lat), 512'(12));
        check_eq("lone_info", 512'(bus.winning_information), 512'(2'b00));
        check_eq("lone_marked", bus.board_marked, b);
        check_eq("lone_count", 512'(dut.move_count_q), 512'(1));
        release_out();
        check_eq("release_out_cont", 512'(bus.out_cont_signal), 512'(0));

        // Horizontal black five, last move in the middle
        do_reset();
        b = '0; exp_b = '0;
        for (int x = 3; x <= 7; x++) begin
            b = put(b, x, 4, 2'd1);
            exp_b = put(exp_b, x, 4, 2'd3);
        end
        b = put(b, 9, 4, 2'd1); exp_b = put(exp_b, 9, 4, 2'd1);
        b = put(b, 5, 5, 2'd2); exp_b = put(exp_b, 5, 5, 2'd2);
        bus.board = b; bus.last_x = 4'd5; bus.last_y = 4'd4;
        run_check(lat);
        check_eq("horiz_lat", 512'(lat), 512'(12));
        check_eq("horiz_info", 512'(bus.winning_information), 512'(2'b10));
        check_eq("horiz_marked", bus.board_marked, exp_b);
        release_out();

        // Blue diagonal from the corner; (15,15) must not be reached by wrapping
        do_reset();
        b = '0; exp_b = '0;
        for (int i = 0; i <= 4; i++) begin
            b = put(b, i, i, 2'd2);
            exp_b = put(exp_b, i, i, 2'd3);
        end
        b = put(b, 15, 15, 2'd2); exp_b = put(exp_b, 15, 15, 2'd2);
        bus.board = b; bus.last_x = 4'd0; bus.last_y = 4'd0;
        run_check(lat);
        check_eq("diag_lat", 512'(lat), 512'(17));
        check_eq("diag_info", 512'(bus.winning_information), 512'(2'b11));
        check_eq("diag_marked", bus.board_marked, exp_b);
        release_out();

        // Four at the right edge plus a stone that a row wrap would join
        do_reset();
        b = '0;
        for (int x = 12; x <= 15; x++) b = put(b, x, 9, 2'd1);
        b = put(b, 0, 10, 2'd1);
        bus.board = b; bus.last_x = 4'd15; bus.last_y = 4'd9;
        run_check(lat);
        check_eq("edge_lat", 512'(lat), 512'(15));
        check_eq("edge_info", 512'(bus.winning_information), 512'(2'b00));
        check_eq("edge_marked", bus.board_marked, b);
        release_out();

        // 256 non-winning checks give a draw, then the sticky result skips
        do_reset();
        b = put('0, 7, 7, 2'd1);
        bus.board = b; bus.last_x = 4'd7; bus.last_y = 4'd7;
        bad_lat = 0;
        for (int i = 1; i <= 256; i++) begin
            run_check(lat);
            if (lat != 12) bad_lat++;
            if (i == 255) check_eq("draw_info_255", 512'(bus.winning_information), 512'(2'b00));
            release_out();
        end
        check_eq("draw_lat_all", 512'(bad_lat), 512'(0));
        check_eq("draw_info_256", 512'(bus.winning_information), 512'(2'b01));
        check_eq("draw_count", 512'(dut.move_count_q), 512'(256));
        run_check(lat);
        check_eq("skip_lat", 512'(lat), 512'(0));
        check_eq("skip_count", 512'(dut.move_count_q), 512'(256));
        check_eq("skip_info", 512'(bus.winning_information), 512'(2'b01));
        check_eq("skip_marked", bus.board_marked, b);
        release_out();

        // Reset during WALK_NEG aborts at once
        do_reset();
        @(negedge clk);
        bus.in_cont_signal = 1'b1;
        @(posedge clk);
        #1;
        bus.in_cont_signal = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("abort_out_cont", 512'(bus.out_cont_signal), 512'(0));
        check_eq("abort_info", 512'(bus.winning_information), 512'(0));
        check_eq("abort_marked", bus.board_marked, '0);
        @(negedge clk);
        rst_n = 1'b1;
        run_check(lat);
        check_eq("after_abort_lat", 512'(lat), 512'(12));
        check_eq("after_abort_marked", bus.board_marked, b);

        // Downstream stall: out_cont_signal must hold
        hi = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (bus.out_cont_signal) hi++;
        end
        check_eq("hold_out_cont", 512'(hi), 512'(20));
        release_out();
        check_eq("hold_release", 512'(bus.out_cont_signal), 512'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
